// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and constants for the data memory controller
package riscv_mem_pkg;

    localparam int XLEN   = 32;
    localparam int MASK_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Expand a byte-lane mask into a full-width bit mask
    function automatic logic [XLEN-1:0] lane_mask(input logic [MASK_W-1:0] m);
        logic [XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < MASK_W; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// rtl/data_mem_array.sv - single-port synchronous word RAM with byte write enables
module data_mem_array
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic [MASK_W-1:0] we,
    input  logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    // Byte-lane write and registered read of the addressed word; no reset on contents
    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - wait-state data memory controller with range and conflict checks
module data_mem_ctrl
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_rd_en_ma,
    input  logic              data_wr_en_ma,
    input  logic [XLEN-1:0]   data_addr,
    input  logic [XLEN-1:0]   data_wr,
    input  logic [MASK_W-1:0] data_rd_en_ctrl,
    output logic              data_ready,
    output logic [XLEN-1:0]   data_rd,
    output logic              access_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [31:0] DEPTH_L  = 32'(DEPTH_WORDS);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q;
    logic              rd_q, wr_q, oor_q;
    logic [AW-1:0]     idx_q;
    logic [XLEN-1:0]   wdata_q;
    logic [MASK_W-1:0] mask_q;
    logic [XLEN-1:0]   data_rd_q;

    logic              req, accept, addr_oor, resp_go, err_q, rd_update;
    logic [AW-1:0]     ram_addr;
    logic [MASK_W-1:0] ram_we;
    logic [XLEN-1:0]   ram_rdata, rd_next;
    logic              unused_addr_lsb;

    assign req             = data_rd_en_ma | data_wr_en_ma;
    assign accept          = (state_q == IDLE) && req;
    assign addr_oor        = {2'b00, data_addr[31:2]} >= DEPTH_L;
    assign unused_addr_lsb = ^data_addr[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic: IDLE -> (WAIT) -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req) state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT: if (cnt_q == 4'd0) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Wait-state down-counter, loaded as the request is accepted
    always_ff @(posedge clk) begin
        if (reset)                                 cnt_q <= 4'd0;
        else if (accept)                           cnt_q <= CNT_LOAD;
        else if (state_q == WAIT && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end

    // Request latches; inputs are ignored outside IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            oor_q  <= 1'b0;
            idx_q  <= '0;
            mask_q <= '0;
        end else if (accept) begin
            rd_q    <= data_rd_en_ma;
            wr_q    <= data_wr_en_ma;
            oor_q   <= addr_oor;
            idx_q   <= data_addr[AW+1:2];
            mask_q  <= data_rd_en_ctrl;
            wdata_q <= data_wr;
        end
    end

    // In IDLE the RAM sees the live address so the word is ready by RESP even with no wait states
    assign ram_addr = (state_q == IDLE) ? data_addr[AW+1:2] : idx_q;

    // Reset during RESP must suppress both the write and the strobe
    assign resp_go   = (state_q == RESP) && !reset;
    assign err_q     = oor_q | (rd_q & wr_q);
    assign ram_we    = (resp_go && wr_q && !rd_q && !oor_q) ? mask_q : '0;
    assign rd_update = resp_go && rd_q && !wr_q;
    assign rd_next   = oor_q ? '0 : (ram_rdata & lane_mask(mask_q));

    assign data_ready = resp_go;
    assign access_err = resp_go && err_q;
    assign data_rd    = rd_update ? rd_next : data_rd_q;

    // Hold the last read result between read responses
    always_ff @(posedge clk) begin
        if (reset)          data_rd_q <= '0;
        else if (rd_update) data_rd_q <= rd_next;
    end

    data_mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words stored; power of two.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states inserted before each response; range 0..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 data_rd_en_ma  input  1  read request from the CPU memory-access stage.
REQ-006 data_wr_en_ma  input  1  write request from the CPU memory-access stage.
REQ-007 data_addr  input  32  byte address of the access; word index is data_addr[31:2].
REQ-008 data_wr  input  32  write data, little-endian byte lanes.
REQ-009 data_rd_en_ctrl  input  4  byte-lane mask; bit i selects data bits [8i+7:8i].
REQ-010 data_ready  output  1  one-cycle response strobe completing the current request.
REQ-011 data_rd  output  32  read data; valid when data_ready is high.
REQ-012 access_err  output  1  error flag; asserted only together with data_ready.

Function
REQ-013 FSM states SHALL be IDLE, WAIT and RESP.
REQ-014 In IDLE, a request (rd_en or wr_en high) SHALL latch addr, wr data, mask and request type; the FSM goes to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 WAIT SHALL load a down-counter with WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESP when the counter reads 0.
REQ-016 In RESP, the controller SHALL perform the access, drive data_ready=1 for exactly one cycle, then return to IDLE.
REQ-017 Latency: request first seen in IDLE at cycle T SHALL produce data_ready at T+1+WAIT_CYCLES.
REQ-018 Inputs sampled after the latch SHALL be ignored until the next IDLE; the CPU holds its request until data_ready.
REQ-019 A request held high after data_ready SHALL be accepted as a new request in the IDLE cycle that follows RESP (one idle bubble minimum).
REQ-020 Read: data_rd SHALL equal the stored word with disabled lanes forced to 0; data_rd holds its value until the next read response.
REQ-021 Write: only lanes with mask bit 1 SHALL be updated; mask 4'b0000 SHALL leave memory unchanged yet still respond with data_ready.
REQ-022 data_addr[1:0] SHALL be ignored; all accesses are word-aligned.
REQ-023 Out of range (word index >= DEPTH_WORDS): write dropped, read returns 0, access_err=1.
REQ-024 rd_en and wr_en both high: no memory change, data_rd unchanged, access_err=1.
REQ-025 Memory contents SHALL have no reset and are undefined until written.

Reset
REQ-026 On reset, state SHALL become IDLE, counter=0, data_ready=0, access_err=0 and data_rd=32'h0.
REQ-027 Reset asserted mid-request (WAIT or RESP) SHALL abort it with no memory write and no data_ready strobe.
REQ-028 The first request SHALL be accepted in the first cycle after reset deasserts.

Structure
REQ-029 Shared package riscv_mem_pkg SHALL hold the FSM state enum, XLEN=32, and the mask width constant (4).
REQ-030 Storage SHALL be a sub-module data_mem_array: single-port, synchronous, word-wide RAM with a 4-bit byte write enable.
REQ-031 data_mem_ctrl SHALL contain the FSM, the wait counter, the request latches, range check and output registers.

Verification
REQ-032 WAIT_CYCLES=2: write 0xDEADBEEF @0x10 mask 4'hF, then read @0x10 mask 4'hF -> each data_ready 3 cycles after request; read returns 0xDEADBEEF.
REQ-033 Write 0x000000AA @0x10 mask 4'h1 over 0xDEADBEEF, read mask 4'hF -> 0xDEADBEAA; read mask 4'h6 -> 0x00ADBE00.
REQ-034 WAIT_CYCLES=0, rd_en held high for 6 cycles @0x0 -> data_ready pulses every 2 cycles (back-to-back with one IDLE bubble).
REQ-035 Read @0x1000 with DEPTH_WORDS=1024 -> data_ready=1, access_err=1, data_rd=0; rd_en+wr_en together @0x4 -> access_err=1, memory unchanged.
REQ-036 Write request issued, reset pulsed during WAIT, then read same address -> no data_ready before reset; read returns prior contents.
